// File: rtl/pcie_dll_acknak_sched_pkg.sv
// ============================================================================
//  Module   : pcie_dll_acknak_sched_pkg
//  Purpose  : Shared DLL types, ACK/NAK DLLP layout, constants and builders
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pcie_dll_acknak_sched_pkg;

    localparam int NEXT_RCV_SEQ_BITS = 12;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    // ACK/NAK DLLP: type byte, 12 reserved bits, 12-bit seq, CRC16 (filled downstream)
    typedef struct packed {
        logic [7:0]                   dllp_type;
        logic [11:0]                  reserved;
        logic [NEXT_RCV_SEQ_BITS-1:0] seq;
        logic [15:0]                  crc16;
    } dllp_ACKNAK_packet_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } acknak_state_e;

    function automatic dllp_ACKNAK_packet_t gen_dllp_ACK(input logic [NEXT_RCV_SEQ_BITS-1:0] seq);
        dllp_ACKNAK_packet_t pkt;
        pkt.dllp_type = DLLP_TYPE_ACK;
        pkt.reserved  = '0;
        pkt.seq       = seq;
        pkt.crc16     = '0;
        return pkt;
    endfunction

    function automatic dllp_ACKNAK_packet_t gen_dllp_NAK(input logic [NEXT_RCV_SEQ_BITS-1:0] seq);
        dllp_ACKNAK_packet_t pkt;
        pkt.dllp_type = DLLP_TYPE_NAK;
        pkt.reserved  = '0;
        pkt.seq       = seq;
        pkt.crc16     = '0;
        return pkt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_dll_acknak_timer.sv
// ============================================================================
//  Module   : pcie_dll_acknak_timer
//  Purpose  : AckNak latency timer with start / clear and expire indication
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pcie_dll_acknak_timer #(
    parameter int LATENCY = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             running_q, running_d;

    assign o_expire = running_q && (count_q >= EXPIRE_AT);

    // Next count: clear wins, expiry stops, otherwise count or start.
    // The start cycle itself is the first latency tick, so the load value is 1
    // and the ACK leaves LATENCY cycles after the accepting TLP.
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        if (i_clear || o_expire) begin
            count_d   = '0;
            running_d = 1'b0;
        end else if (running_q) begin
            count_d = count_q + 1'b1;
        end else if (i_start) begin
            count_d   = CNT_W'(1);
            running_d = 1'b1;
        end
    end

    // Timer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcie_dll_acknak_sched.sv
// ============================================================================
//  Module   : pcie_dll_acknak_sched
//  Purpose  : RX DLL ACK/NAK scheduler - TLP sequence check and DLLP issue
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pcie_dll_acknak_sched
    import pcie_dll_acknak_sched_pkg::*;
#(
    parameter int SEQ_BITS    = 12,
    parameter int ACK_LATENCY = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dl_up,
    input  logic                tlp_valid,
    input  logic [SEQ_BITS-1:0] tlp_seq,
    input  logic                tlp_lcrc_ok,
    output logic                tlp_accept,
    output logic                tlp_discard,
    output logic [SEQ_BITS-1:0] next_rcv_seq,
    output logic                dllp_valid,
    input  logic                dllp_ready,
    output logic [47:0]         dllp_pkt
);

    // Distances 1..HALF behind NEXT_RCV_SEQ are duplicates; anything else is ahead
    localparam logic [SEQ_BITS-1:0] SEQ_HALF = {1'b1, {(SEQ_BITS-1){1'b0}}};

    acknak_state_e       state_q, state_d;
    logic [SEQ_BITS-1:0] next_rcv_seq_q, next_rcv_seq_d;
    logic                nak_sched_q, nak_sched_d;
    logic                ack_req_q, ack_req_d;
    logic                nak_req_q, nak_req_d;
    logic                unacked_q, unacked_d;
    logic                tlp_accept_q, tlp_accept_d;
    logic                tlp_discard_q, tlp_discard_d;
    dllp_ACKNAK_packet_t dllp_pkt_q, dllp_pkt_d;

    logic [SEQ_BITS-1:0] seq_diff;
    logic [SEQ_BITS-1:0] ack_seq;
    logic                timer_start;
    logic                timer_clear;
    logic                timer_expire;

    pcie_dll_acknak_timer #(
        .LATENCY (ACK_LATENCY),
        .CNT_W   (16)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_start  (timer_start),
        .i_clear  (timer_clear || !dl_up),
        .o_expire (timer_expire)
    );

    // TLP classification, request bookkeeping and the IDLE/SEND output FSM
    always_comb begin
        state_d        = state_q;
        next_rcv_seq_d = next_rcv_seq_q;
        nak_sched_d    = nak_sched_q;
        ack_req_d      = ack_req_q;
        nak_req_d      = nak_req_q;
        unacked_d      = unacked_q;
        dllp_pkt_d     = dllp_pkt_q;
        tlp_accept_d   = 1'b0;
        tlp_discard_d  = 1'b0;
        timer_start    = 1'b0;
        timer_clear    = 1'b0;
        seq_diff       = next_rcv_seq_q - tlp_seq;
        ack_seq        = '0;

        if (tlp_valid) begin
            if (tlp_lcrc_ok && (seq_diff == '0)) begin
                tlp_accept_d   = 1'b1;
                next_rcv_seq_d = next_rcv_seq_q + 1'b1;
                nak_sched_d    = 1'b0;
                unacked_d      = 1'b1;
                timer_start    = 1'b1;
            end else if (tlp_lcrc_ok && (seq_diff <= SEQ_HALF)) begin
                tlp_discard_d = 1'b1;
                ack_req_d     = 1'b1;
            end else begin
                // Bad LCRC or ahead of sequence: one NAK per scheduling window
                tlp_discard_d = 1'b1;
                if (!nak_sched_q) begin
                    nak_req_d   = 1'b1;
                    nak_sched_d = 1'b1;
                end
            end
        end

        if (timer_expire) begin
            ack_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (nak_req_q || ack_req_q) begin
                    // Seq reflects a same-cycle accept, so the latch covers it
                    // and clearing unacked/timer over a same-cycle start is safe.
                    ack_seq = next_rcv_seq_d - 1'b1;
                    state_d = ST_SEND;
                    if (nak_req_q) begin
                        dllp_pkt_d = gen_dllp_NAK(ack_seq);
                        nak_req_d  = 1'b0;
                    end else begin
                        dllp_pkt_d = gen_dllp_ACK(ack_seq);
                    end
                    ack_req_d   = 1'b0;
                    unacked_d   = 1'b0;
                    timer_clear = 1'b1;
                end
            end
            ST_SEND: begin
                if (dllp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; DL_Inactive has the same effect as reset
    always_ff @(posedge clk) begin
        if (rst || !dl_up) begin
            state_q        <= ST_IDLE;
            next_rcv_seq_q <= '0;
            nak_sched_q    <= 1'b0;
            ack_req_q      <= 1'b0;
            nak_req_q      <= 1'b0;
            unacked_q      <= 1'b0;
            tlp_accept_q   <= 1'b0;
            tlp_discard_q  <= 1'b0;
            dllp_pkt_q     <= '0;
        end else begin
            state_q        <= state_d;
            next_rcv_seq_q <= next_rcv_seq_d;
            nak_sched_q    <= nak_sched_d;
            ack_req_q      <= ack_req_d;
            nak_req_q      <= nak_req_d;
            unacked_q      <= unacked_d;
            tlp_accept_q   <= tlp_accept_d;
            tlp_discard_q  <= tlp_discard_d;
            dllp_pkt_q     <= dllp_pkt_d;
        end
    end

    assign tlp_accept   = tlp_accept_q;
    assign tlp_discard  = tlp_discard_q;
    assign next_rcv_seq = next_rcv_seq_q;
    assign dllp_valid   = (state_q == ST_SEND);
    assign dllp_pkt     = dllp_pkt_q;

endmodule

`default_nettype wire
